// File: rtl/multi_period_timer_pkg.sv
// Shared definitions for multi_period_timer: channel state encoding, mode values
// and the prescaler width helper.
package multi_period_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  // Enough bits to count 0..cpt-1, never less than one bit.
  function automatic int unsigned presc_width(input int unsigned cpt);
    return (cpt <= 2) ? 1 : $clog2(cpt);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Base-tick prescaler: counts 0..CLK_PER_TICK-1 while enabled and flags a tick
// in the cycle it wraps. A clear restarts the phase and takes priority over enable.
module tick_prescaler
  import multi_period_timer_pkg::*;
#(
  parameter int unsigned CLK_PER_TICK = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = presc_width(CLK_PER_TICK);
  localparam logic [W-1:0] CNT_MAX = W'(CLK_PER_TICK - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && !clr && (cnt == CNT_MAX);

endmodule

// File: rtl/multi_period_timer.sv
// CHANNELS independent one-shot/periodic timers, each with its own prescaler.
// Optional macro MULTI_PERIOD_TIMER_PAUSE_EN adds a per-channel pause input.
module multi_period_timer
  import multi_period_timer_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned PERIOD_W     = 16,
  parameter int unsigned CLK_PER_TICK = 100000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CHANNELS-1:0]          start,
  input  logic [CHANNELS-1:0]          stop,
  input  logic [CHANNELS-1:0]          mode,
  input  logic [CHANNELS*PERIOD_W-1:0] period,
`ifdef MULTI_PERIOD_TIMER_PAUSE_EN
  input  logic [CHANNELS-1:0]          pause,
`endif
  output logic [CHANNELS-1:0]          busy,
  output logic [CHANNELS-1:0]          expire,
  output logic [CHANNELS-1:0]          zero_err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t                state, state_n;
    logic [PERIOD_W-1:0]   cnt, cnt_n, per, per_n, per_in, cnt_inc;
    logic                  mode_q, mode_n;
    logic                  exp_q, exp_n, zerr_q, zerr_n;
    logic                  tick, tick_en, presc_clr;

    assign per_in  = period[i*PERIOD_W +: PERIOD_W];
    assign cnt_inc = cnt + 1'b1;

`ifdef MULTI_PERIOD_TIMER_PAUSE_EN
    assign tick_en = (state == ST_RUN) && !pause[i];
`else
    assign tick_en = (state == ST_RUN);
`endif
    assign presc_clr = start[i] || stop[i];

    tick_prescaler #(
      .CLK_PER_TICK(CLK_PER_TICK)
    ) u_presc (
      .clk  (clk),
      .rst  (rst),
      .clr  (presc_clr),
      .en   (tick_en),
      .tick (tick)
    );

    always_comb begin
      state_n = state;
      cnt_n   = cnt;
      per_n   = per;
      mode_n  = mode_q;
      exp_n   = 1'b0;
      zerr_n  = 1'b0;
      if (stop[i]) begin
        state_n = ST_IDLE;
      end else if (start[i]) begin
        // A zero-period start also aborts a running channel: it could never expire.
        if (per_in == '0) begin
          zerr_n  = 1'b1;
          state_n = ST_IDLE;
        end else begin
          state_n = ST_RUN;
          per_n   = per_in;
          mode_n  = mode[i];
          cnt_n   = '0;
        end
      end else if (state == ST_RUN && tick) begin
        if (cnt_inc == per) begin
          exp_n = 1'b1;
          cnt_n = '0;
          if (mode_q == MODE_ONESHOT) begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt_inc;
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        per    <= '0;
        mode_q <= MODE_ONESHOT;
        exp_q  <= 1'b0;
        zerr_q <= 1'b0;
      end else begin
        state  <= state_n;
        cnt    <= cnt_n;
        per    <= per_n;
        mode_q <= mode_n;
        exp_q  <= exp_n;
        zerr_q <= zerr_n;
      end
    end

    assign busy[i]     = (state == ST_RUN);
    assign expire[i]   = exp_q;
    assign zero_err[i] = zerr_q;
  end

endmodule

// File: tb/tb_multi_period_timer.sv
// Scoreboard bench for multi_period_timer (CHANNELS=4, PERIOD_W=16, CLK_PER_TICK=10).
module tb_multi_period_timer;

  localparam int CH  = 4;
  localparam int PW  = 16;
  localparam int CPT = 10;
  localparam int K_EXP  = 0;
  localparam int K_ZERR = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [CH-1:0]     start = '0;
  logic [CH-1:0]     stop = '0;
  logic [CH-1:0]     mode = '0;
  logic [CH*PW-1:0]  period = '0;
`ifdef MULTI_PERIOD_TIMER_PAUSE_EN
  logic [CH-1:0]     pause = '0;
`endif
  logic [CH-1:0]     busy, expire, zero_err;

  multi_period_timer #(
    .CHANNELS(CH),
    .PERIOD_W(PW),
    .CLK_PER_TICK(CPT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .period   (period),
`ifdef MULTI_PERIOD_TIMER_PAUSE_EN
    .pause    (pause),
`endif
    .busy     (busy),
    .expire   (expire),
    .zero_err (zero_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;
  ev_t sb[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic void push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = kind;
    sb.push_back(e);
  endfunction

  task automatic observe(input int ch, input int kind);
    int idx = -1;
    for (int k = 0; k < sb.size(); k++) begin
      if (idx < 0 && sb[k].ch == ch && sb[k].kind == kind) idx = k;
    end
    if (idx < 0) begin
      chk($sformatf("unexpected_%s_ch%0d", kind == K_EXP ? "expire" : "zero_err", ch), cyc, -1);
    end else begin
      chk($sformatf("%s_ch%0d_cycle", kind == K_EXP ? "expire" : "zero_err", ch), cyc, sb[idx].cyc);
      sb.delete(idx);
    end
  endtask

  // Monitor: every output pulse must match a pending scoreboard entry.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (expire[c])   observe(c, K_EXP);
      if (zero_err[c]) observe(c, K_ZERR);
    end
  end

  task automatic step();
    @(negedge clk);
    start = '0;
    stop  = '0;
  endtask

  task automatic go(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Sets up a start on channel ch for the next edge; t is that edge's index.
  task automatic arm(input int ch, input int p, input logic m, output int t);
    period[ch*PW +: PW] = p[PW-1:0];
    mode[ch]  = m;
    start[ch] = 1'b1;
    t = cyc + 1;
  endtask

  int t, t2;

  initial begin
    // Reset held with random inputs
    for (int k = 0; k < 5; k++) begin
      start  = 4'($urandom);
      stop   = 4'($urandom);
      mode   = 4'($urandom);
      period = {$urandom, $urandom};
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_expire", int'(expire), 0);
      chk("rst_zero_err", int'(zero_err), 0);
    end
    start = '0; stop = '0; mode = '0; period = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // One-shot ch0 period 3
    arm(0, 3, 1'b0, t);
    push(t + 30, 0, K_EXP);
    step();
    chk("os_busy_T", int'(busy[0]), 1);
    go(t + 29); chk("os_busy_T29", int'(busy[0]), 1);
    go(t + 30); chk("os_busy_T30", int'(busy[0]), 0);
    go(t + 70);

    // Periodic ch1 period 2, stop at T+65
    arm(1, 2, 1'b1, t);
    push(t + 20, 1, K_EXP); push(t + 40, 1, K_EXP); push(t + 60, 1, K_EXP);
    step();
    go(t + 64); stop[1] = 1'b1; step();
    chk("per_stop65_busy", int'(busy[1]), 0);
    go(t + 100);

    // Periodic rerun, stop coinciding with expiry at T+80
    arm(1, 2, 1'b1, t2);
    push(t2 + 20, 1, K_EXP); push(t2 + 40, 1, K_EXP); push(t2 + 60, 1, K_EXP);
    step();
    go(t2 + 79); stop[1] = 1'b1; step();
    chk("per_stop80_busy", int'(busy[1]), 0);
    go(t2 + 100);

    // Restart ch2: period 5 at T, period 2 at T+25
    arm(2, 5, 1'b0, t);
    step();
    go(t + 24);
    arm(2, 2, 1'b0, t2);
    push(t + 45, 2, K_EXP);
    step();
    chk("restart_busy", int'(busy[2]), 1);
    go(t + 46); chk("restart_done_busy", int'(busy[2]), 0);
    go(t + 80);

    // Zero period on ch3
    arm(3, 0, 1'b0, t);
    push(t, 3, K_ZERR);
    step();
    chk("zero_busy", int'(busy[3]), 0);
    go(t + 10);

    // Start and stop on the same edge
    arm(0, 4, 1'b0, t);
    stop[0] = 1'b1;
    step();
    chk("startstop_busy", int'(busy[0]), 0);
    go(t + 60);

    // All channels together, periods 1..4
    for (int c = 0; c < CH; c++) begin
      arm(c, c + 1, 1'b0, t);
      push(t + (c + 1) * CPT, c, K_EXP);
    end
    step();
    chk("conc_busy", int'(busy), 15);
    go(t + 25); chk("conc_busy_T25", int'(busy), 4'b1100);
    go(t + 60);

    // Asynchronous reset mid-run
    arm(0, 3, 1'b1, t);
    step();
    go(t + 15);
    chk("midrst_busy_before", int'(busy[0]), 1);
    #2 rst = 1'b0;
    #1 chk("midrst_busy_async", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    go(t + 80);
    chk("midrst_busy_after", int'(busy), 0);

`ifdef MULTI_PERIOD_TIMER_PAUSE_EN
    // Pause ch0 for edges T+12..T+18
    arm(0, 3, 1'b0, t);
    push(t + 37, 0, K_EXP);
    step();
    go(t + 11); pause[0] = 1'b1;
    go(t + 18); pause[0] = 1'b0;
    go(t + 30); chk("pause_busy_T30", int'(busy[0]), 1);
    go(t + 60);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
